// File: rtl/sync_decoder_scan.sv
// Registered SEL_W-to-NUM_OUT one-hot decoder with DIRECT (handshaked select) and SCAN (self-timed walk) modes.
// Optional macro DECODE_ERR_EN adds the err port: out-of-range selects hold the output and pulse err.
module sync_decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DWELL   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   scan_idx,
  output logic               wrap,
`ifdef DECODE_ERR_EN
  output logic               err,
`endif
  output logic [1:0]         state_dbg
);

  // Handshake: a select is accepted on every rising edge where the block is in
  // (or entering) DIRECT and sel_valid=1; there is no ready, the decoder never stalls.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]   IDX_LAST   = (SEL_W + 1)'(NUM_OUT - 1);
  localparam logic [SEL_W:0]   IDX_LIMIT  = (SEL_W + 1)'(NUM_OUT);

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
  logic               wrap_q, wrap_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
`ifdef DECODE_ERR_EN
  logic               err_q, err_d;
`endif

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] r;
    for (int i = 0; i < NUM_OUT; i++) begin
      r[i] = ({1'b0, idx} == (SEL_W + 1)'(i));
    end
    return r;
  endfunction

  always_comb begin
    if (!en)       state_d = ST_IDLE;
    else if (mode) state_d = ST_SCAN;
    else           state_d = ST_DIRECT;

    out_d       = out_q;
    out_valid_d = out_valid_q;
    scan_idx_d  = '0;
    wrap_d      = 1'b0;
    dwell_d     = '0;
`ifdef DECODE_ERR_EN
    err_d       = 1'b0;
`endif

    case (state_d)
      ST_DIRECT: begin
        if (state_q != ST_DIRECT) begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end
        // An accepted select on the entry edge overrides the entry clear.
        if (sel_valid) begin
          if ({1'b0, sel} < IDX_LIMIT) begin
            out_d       = onehot(sel);
            out_valid_d = 1'b1;
          end else begin
`ifdef DECODE_ERR_EN
            err_d       = 1'b1;
`else
            out_d       = '0;
            out_valid_d = 1'b0;
`endif
          end
        end
      end
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          scan_idx_d = '0;
          dwell_d    = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ({1'b0, scan_idx_q} == IDX_LAST) begin
            scan_idx_d = '0;
            wrap_d     = 1'b1;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end else begin
          dwell_d    = dwell_q + 1'b1;
          scan_idx_d = scan_idx_q;
        end
        out_d       = onehot(scan_idx_d);
        out_valid_d = 1'b1;
      end
      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      scan_idx_q  <= '0;
      wrap_q      <= 1'b0;
      dwell_q     <= '0;
`ifdef DECODE_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      scan_idx_q  <= scan_idx_d;
      wrap_q      <= wrap_d;
      dwell_q     <= dwell_d;
`ifdef DECODE_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign scan_idx  = scan_idx_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;
`ifdef DECODE_ERR_EN
  assign err       = err_q;
`endif

endmodule
